triangle_rasterizer: RTL and testbench

//  Stage directly downstream of projection. Accepts one screen-space Face_t per handshake.

---
 rtl/triangle_rasterizer_pkg.sv | 70 +++++++
 rtl/triangle_rasterizer_edge_eval.sv | 40 ++++
 rtl/triangle_rasterizer.sv | 197 +++++++++++++++++++
 tb/tb_triangle_rasterizer.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/triangle_rasterizer_pkg.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module      : triangle_rasterizer_pkg
//  Description : Primitive types shared by the triangle rasterizer: projected
//                face, fragment, rasterizer state and coordinate helpers.
//  Revision    : 1.0  initial release
// ============================================================================
package triangle_rasterizer_pkg;

   // Vertex .i/.j are 16.8 fixed point; the rasterizer uses a 9-bit integer
   // part so vertices up to 511 keep their true position while the bbox is
   // clamped to the screen.
   localparam int c_FIX_W   = 24;
   localparam int c_FRAC_W  = 8;
   localparam int c_COORD_W = 9;
   localparam int c_DIFF_W  = c_COORD_W + 1;
   localparam int c_EDGE_W  = 2 * c_DIFF_W;
   localparam int c_ID_W    = 7;

   typedef struct packed {
      logic [4:0] r;
      logic [5:0] g;
      logic [4:0] b;
   } Color_t;

   typedef struct packed {
      logic [c_FIX_W-1:0] i;
      logic [c_FIX_W-1:0] j;
   } Vertex_t;

   typedef struct packed {
      Vertex_t v0;
      Vertex_t v1;
      Vertex_t v2;
      Color_t  color;
   } Face_t;

   typedef struct packed {
      logic [7:0]        x;
      logic [7:0]        y;
      Color_t            color;
      logic [c_ID_W-1:0] id;
   } Fragment_t;

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      SETUP = 3'd1,
      SCAN  = 3'd2,
      DRAIN = 3'd3,
      DROP  = 3'd4,
      DONE  = 3'd5
   } RasterState_t;

   // Integer part of a fixed-point coordinate; values beyond the 9-bit range
   // saturate rather than wrap.
   function automatic logic [c_COORD_W-1:0] fix_to_coord(input logic [c_FIX_W-c_FRAC_W-1:0] ipart);
      if (|ipart[c_FIX_W-c_FRAC_W-1:c_COORD_W])
         return '1;
      return ipart[c_COORD_W-1:0];
   endfunction

   // Clamp a vertex coordinate to the last on-screen pixel.
   function automatic logic [7:0] clamp_coord(input logic [c_COORD_W-1:0] v,
                                              input logic [c_COORD_W-1:0] max_v);
      return 8'((v > max_v) ? max_v : v);
   endfunction

endpackage
`default_nettype wire

// File: rtl/triangle_rasterizer_edge_eval.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module      : triangle_rasterizer_edge_eval
//  Description : Combinational edge function
//                E(x,y) = (x-xa)*(yb-ya) - (y-ya)*(xb-xa), signed.
//  Revision    : 1.0  initial release
// ============================================================================
module triangle_rasterizer_edge_eval
   import triangle_rasterizer_pkg::*;
(
   input  logic        [c_COORD_W-1:0] xa,
   input  logic        [c_COORD_W-1:0] ya,
   input  logic        [c_COORD_W-1:0] xb,
   input  logic        [c_COORD_W-1:0] yb,
   input  logic        [7:0]           x,
   input  logic        [7:0]           y,
   output logic signed [c_EDGE_W-1:0]  e
);

   logic signed [c_DIFF_W-1:0] w_dxp;
   logic signed [c_DIFF_W-1:0] w_dyp;
   logic signed [c_DIFF_W-1:0] w_dxe;
   logic signed [c_DIFF_W-1:0] w_dye;
   logic signed [c_EDGE_W-1:0] w_pa;
   logic signed [c_EDGE_W-1:0] w_pb;

   // Differences are formed from zero-extended operands, products in full width
   always_comb begin
      w_dxp = $signed({2'b00, x}) - $signed({1'b0, xa});
      w_dyp = $signed({2'b00, y}) - $signed({1'b0, ya});
      w_dxe = $signed({1'b0, xb}) - $signed({1'b0, xa});
      w_dye = $signed({1'b0, yb}) - $signed({1'b0, ya});
      w_pa  = c_EDGE_W'(w_dxp) * c_EDGE_W'(w_dye);
      w_pb  = c_EDGE_W'(w_dyp) * c_EDGE_W'(w_dxe);
      e     = w_pa - w_pb;
   end

endmodule
`default_nettype wire

// File: rtl/triangle_rasterizer.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module      : triangle_rasterizer
//  Description : Scans the clamped bounding box of one projected face per
//                handshake, one pixel per cycle, and emits a flat-shaded
//                fragment for every pixel covered by the three edge functions.
//                Optional macro BACKFACE_CULL_EN: drop faces with area <= 0.
//  Revision    : 1.0  initial release
// ============================================================================
module triangle_rasterizer
   import triangle_rasterizer_pkg::*;
#(
   parameter int SCREEN_W = 256,
   parameter int SCREEN_H = 256,
   parameter int ID_BITS  = 7
)(
   input  logic               clk,
   input  logic               reset,
   input  Face_t              face_i,
   input  logic [ID_BITS-1:0] face_id_i,
   input  logic               face_valid,
   output logic               face_ready,
   output logic [7:0]         frag_x,
   output logic [7:0]         frag_y,
   output Color_t             frag_color,
   output logic [ID_BITS-1:0] frag_id,
   output logic               frag_valid,
   input  logic               frag_ready,
   output logic               busy,
   output logic               face_done
);

   localparam logic [c_COORD_W-1:0] c_XMAX = c_COORD_W'(SCREEN_W - 1);
   localparam logic [c_COORD_W-1:0] c_YMAX = c_COORD_W'(SCREEN_H - 1);

   RasterState_t               r_state;
   RasterState_t               w_state_next;
   logic [c_COORD_W-1:0]       r_vx [3];
   logic [c_COORD_W-1:0]       r_vy [3];
   Color_t                     r_color;
   logic [ID_BITS-1:0]         r_face_id;
   logic [7:0]                 r_x, r_y, r_xmin, r_xmax, r_ymin, r_ymax;
   logic                       r_area_neg;
   Fragment_t                  r_frag;
   logic                       r_frag_valid;

   logic [c_COORD_W-1:0]       w_xlo, w_xhi, w_ylo, w_yhi;
   logic signed [c_DIFF_W-1:0] w_d1x, w_d1y, w_d2x, w_d2y;
   logic signed [c_EDGE_W-1:0] w_area;
   logic signed [c_EDGE_W-1:0] w_e [3];
   logic                       w_drop, w_covered, w_last_pix, w_advance, w_load;
   logic                       w_unused_frac;

   // Fractional vertex bits carry no weight at pixel resolution
   assign w_unused_frac = ^{face_i.v0.i[c_FRAC_W-1:0], face_i.v0.j[c_FRAC_W-1:0],
                            face_i.v1.i[c_FRAC_W-1:0], face_i.v1.j[c_FRAC_W-1:0],
                            face_i.v2.i[c_FRAC_W-1:0], face_i.v2.j[c_FRAC_W-1:0]};

   // Capture the face on handshake; held unchanged for the whole scan
   always_ff @(posedge clk) begin
      if (face_valid && face_ready) begin
         r_vx[0]   <= fix_to_coord(face_i.v0.i[c_FIX_W-1:c_FRAC_W]);
         r_vy[0]   <= fix_to_coord(face_i.v0.j[c_FIX_W-1:c_FRAC_W]);
         r_vx[1]   <= fix_to_coord(face_i.v1.i[c_FIX_W-1:c_FRAC_W]);
         r_vy[1]   <= fix_to_coord(face_i.v1.j[c_FIX_W-1:c_FRAC_W]);
         r_vx[2]   <= fix_to_coord(face_i.v2.i[c_FIX_W-1:c_FRAC_W]);
         r_vy[2]   <= fix_to_coord(face_i.v2.j[c_FIX_W-1:c_FRAC_W]);
         r_color   <= face_i.color;
         r_face_id <= face_id_i;
      end
   end

   // Bounding box extremes and signed doubled area of the captured face
   always_comb begin
      w_xlo = r_vx[0];
      w_xhi = r_vx[0];
      w_ylo = r_vy[0];
      w_yhi = r_vy[0];
      for (int k = 1; k < 3; k++) begin
         if (r_vx[k] < w_xlo) w_xlo = r_vx[k];
         if (r_vx[k] > w_xhi) w_xhi = r_vx[k];
         if (r_vy[k] < w_ylo) w_ylo = r_vy[k];
         if (r_vy[k] > w_yhi) w_yhi = r_vy[k];
      end
      w_d1x  = $signed({1'b0, r_vx[1]}) - $signed({1'b0, r_vx[0]});
      w_d1y  = $signed({1'b0, r_vy[1]}) - $signed({1'b0, r_vy[0]});
      w_d2x  = $signed({1'b0, r_vx[2]}) - $signed({1'b0, r_vx[0]});
      w_d2y  = $signed({1'b0, r_vy[2]}) - $signed({1'b0, r_vy[0]});
      w_area = c_EDGE_W'(w_d1x) * c_EDGE_W'(w_d2y) - c_EDGE_W'(w_d1y) * c_EDGE_W'(w_d2x);
   end

`ifdef BACKFACE_CULL_EN
   assign w_drop = (w_area == '0) || w_area[c_EDGE_W-1];
`else
   assign w_drop = (w_area == '0);
`endif

   // Edges run v1->v0, v2->v1, v0->v2 so that every E has the sign of the
   // area at interior points; zero-valued edges count as inside.
   for (genvar k = 0; k < 3; k++) begin : g_edge
      triangle_rasterizer_edge_eval u_edge_eval (
         .xa (r_vx[(k + 1) % 3]),
         .ya (r_vy[(k + 1) % 3]),
         .xb (r_vx[k]),
         .yb (r_vy[k]),
         .x  (r_x),
         .y  (r_y),
         .e  (w_e[k])
      );
   end

   assign w_covered = r_area_neg
      ? ((w_e[0][c_EDGE_W-1] || w_e[0] == '0) && (w_e[1][c_EDGE_W-1] || w_e[1] == '0) &&
         (w_e[2][c_EDGE_W-1] || w_e[2] == '0))
      : (!w_e[0][c_EDGE_W-1] && !w_e[1][c_EDGE_W-1] && !w_e[2][c_EDGE_W-1]);

   assign w_last_pix = (r_x == r_xmax) && (r_y == r_ymax);

   // State register
   always_ff @(posedge clk) begin
      if (reset) r_state <= IDLE;
      else       r_state <= w_state_next;
   end

   // Next-state logic and scan/load strobes
   always_comb begin
      w_state_next = r_state;
      w_advance    = 1'b0;
      w_load       = 1'b0;
      case (r_state)
         IDLE:  if (face_valid) w_state_next = SETUP;
         SETUP: w_state_next = w_drop ? DROP : SCAN;
         SCAN: begin
            w_advance = !(r_frag_valid && !frag_ready);
            w_load    = w_advance && w_covered;
            if (w_advance && w_last_pix) w_state_next = DRAIN;
         end
         DRAIN: if (!r_frag_valid || frag_ready) w_state_next = DONE;
         DROP:  w_state_next = DONE;
         DONE:  w_state_next = IDLE;
         default: w_state_next = IDLE;
      endcase
   end

   // Bounding box and scan position: loaded in SETUP, stepped in raster order in SCAN
   always_ff @(posedge clk) begin
      if (reset) begin
         r_x        <= '0;
         r_y        <= '0;
         r_xmin     <= '0;
         r_xmax     <= '0;
         r_ymin     <= '0;
         r_ymax     <= '0;
         r_area_neg <= 1'b0;
      end else if (r_state == SETUP) begin
         r_xmin     <= clamp_coord(w_xlo, c_XMAX);
         r_xmax     <= clamp_coord(w_xhi, c_XMAX);
         r_ymin     <= clamp_coord(w_ylo, c_YMAX);
         r_ymax     <= clamp_coord(w_yhi, c_YMAX);
         r_x        <= clamp_coord(w_xlo, c_XMAX);
         r_y        <= clamp_coord(w_ylo, c_YMAX);
         r_area_neg <= w_area[c_EDGE_W-1];
      end else if (w_advance && !w_last_pix) begin
         if (r_x == r_xmax) begin
            r_x <= r_xmin;
            r_y <= r_y + 8'd1;
         end else begin
            r_x <= r_x + 8'd1;
         end
      end
   end

   // Output register: holds a fragment until accepted; load and accept may coincide
   always_ff @(posedge clk) begin
      if (reset) begin
         r_frag       <= '0;
         r_frag_valid <= 1'b0;
      end else if (w_load) begin
         r_frag       <= '{x: r_x, y: r_y, color: r_color, id: c_ID_W'(r_face_id)};
         r_frag_valid <= 1'b1;
      end else if (frag_ready) begin
         r_frag_valid <= 1'b0;
      end
   end

   assign frag_x     = r_frag.x;
   assign frag_y     = r_frag.y;
   assign frag_color = r_frag.color;
   assign frag_id    = ID_BITS'(r_frag.id);
   assign frag_valid = r_frag_valid;
   assign face_ready = (r_state == IDLE);
   assign busy       = (r_state != IDLE);
   assign face_done  = (r_state == DONE);

endmodule
`default_nettype wire

// File: tb/tb_triangle_rasterizer.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module      : tb_triangle_rasterizer
//  Description : Self-checking bench for triangle_rasterizer. Expected
//                fragments come from a point-in-triangle model over the
//                clamped bounding box in raster order.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_triangle_rasterizer;
   import triangle_rasterizer_pkg::*;

   logic        clk = 1'b0;
   logic        reset;
   Face_t       face_i;
   logic [6:0]  face_id_i;
   logic        face_valid;
   logic        face_ready;
   logic [7:0]  frag_x, frag_y;
   Color_t      frag_color;
   logic [6:0]  frag_id;
   logic        frag_valid;
   logic        frag_ready;
   logic        busy;
   logic        face_done;

   int tests = 0;
   int fails = 0;

   typedef struct { int x; int y; } pix_t;
   pix_t exp_q[$];

   typedef struct {
      string      tag;
      int         x0, y0, x1, y1, x2, y2;
      logic [15:0] col;
      logic [6:0] id;
      int         rmode;      // 0 ready held, 1 toggled, 2 random
      int         exp_cnt;    // -1: model count only
      int         exp_done;   // cycle of face_done after accept, -1: unchecked
      int         exp_first;  // cycle of first frag_valid, -1: unchecked
   } vec_t;

   vec_t vecs[5];

   triangle_rasterizer #(.SCREEN_W(256), .SCREEN_H(256), .ID_BITS(7)) dut (
      .clk        (clk),
      .reset      (reset),
      .face_i     (face_i),
      .face_id_i  (face_id_i),
      .face_valid (face_valid),
      .face_ready (face_ready),
      .frag_x     (frag_x),
      .frag_y     (frag_y),
      .frag_color (frag_color),
      .frag_id    (frag_id),
      .frag_valid (frag_valid),
      .frag_ready (frag_ready),
      .busy       (busy),
      .face_done  (face_done)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   function automatic int orient(input int ax, input int ay, input int bx, input int by,
                                 input int px, input int py);
      return (bx - ax) * (py - ay) - (by - ay) * (px - ax);
   endfunction

   function automatic int lim(input int v);
      return (v > 255) ? 255 : ((v < 0) ? 0 : v);
   endfunction

   // Reference: every pixel of the clamped bbox lying inside or on the triangle
   task automatic model(input int x0, input int y0, input int x1, input int y1,
                        input int x2, input int y2);
      int a, xl, xh, yl, yh;
      exp_q.delete();
      a = orient(x0, y0, x1, y1, x2, y2);
      if (a == 0) return;
`ifdef BACKFACE_CULL_EN
      if (a < 0) return;
`endif
      xl = lim((x0 < x1) ? ((x0 < x2) ? x0 : x2) : ((x1 < x2) ? x1 : x2));
      xh = lim((x0 > x1) ? ((x0 > x2) ? x0 : x2) : ((x1 > x2) ? x1 : x2));
      yl = lim((y0 < y1) ? ((y0 < y2) ? y0 : y2) : ((y1 < y2) ? y1 : y2));
      yh = lim((y0 > y1) ? ((y0 > y2) ? y0 : y2) : ((y1 > y2) ? y1 : y2));
      for (int y = yl; y <= yh; y++) begin
         for (int x = xl; x <= xh; x++) begin
            int e0, e1, e2;
            pix_t p;
            e0 = orient(x0, y0, x1, y1, x, y);
            e1 = orient(x1, y1, x2, y2, x, y);
            e2 = orient(x2, y2, x0, y0, x, y);
            if ((a > 0 && e0 >= 0 && e1 >= 0 && e2 >= 0) ||
                (a < 0 && e0 <= 0 && e1 <= 0 && e2 <= 0)) begin
               p.x = x;
               p.y = y;
               exp_q.push_back(p);
            end
         end
      end
   endtask

   function automatic Face_t make_face(input int x0, input int y0, input int x1, input int y1,
                                       input int x2, input int y2, input logic [15:0] col,
                                       input logic [7:0] frac);
      Face_t f;
      f.v0.i  = {x0[15:0], frac};
      f.v0.j  = {y0[15:0], ~frac};
      f.v1.i  = {x1[15:0], frac ^ 8'h5A};
      f.v1.j  = {y1[15:0], frac};
      f.v2.i  = {x2[15:0], ~frac};
      f.v2.j  = {y2[15:0], frac ^ 8'hA5};
      f.color = col;
      return f;
   endfunction

   // Offer one face, then observe fragments until face_done (or abort after N accepts)
   task automatic run_face(input string tag, input int x0, input int y0, input int x1,
                           input int y1, input int x2, input int y2, input logic [15:0] col,
                           input logic [6:0] id, input int rmode, input int exp_cnt,
                           input int exp_done, input int exp_first, input int abort_after,
                           input logic [7:0] frac, output int last_xy);
      int got, n_exp, done_cnt, done_cyc, first_cyc, cyc, wait_cnt;
      logic stalled;
      logic [38:0] held;
      pix_t p;
      model(x0, y0, x1, y1, x2, y2);
      n_exp = exp_q.size();
      wait_cnt = 0;
      while (!face_ready && wait_cnt < 100) begin
         @(posedge clk); #1;
         wait_cnt++;
      end
      chk({tag, " ready_before_accept"}, face_ready, 1);
      face_i     = make_face(x0, y0, x1, y1, x2, y2, col, frac);
      face_id_i  = id;
      face_valid = 1'b1;
      @(posedge clk); #1;
      face_valid = 1'b0;
      cyc = 1; got = 0; done_cnt = 0; done_cyc = -1; first_cyc = -1;
      stalled = 1'b0; held = '0; last_xy = -1;
      while (cyc < 3000) begin
         case (rmode)
            0:       frag_ready = 1'b1;
            1:       frag_ready = cyc[0];
            default: frag_ready = 1'($urandom_range(0, 1));
         endcase
         // A second face offered while busy must not be captured
         if (cyc == 2) begin
            face_i     = make_face(0, 0, 255, 0, 0, 255, 16'hFFFF, 8'h00);
            face_valid = 1'b1;
         end else begin
            face_valid = 1'b0;
         end
         @(negedge clk);
         if (cyc == 1) chk({tag, " busy_not_ready"}, {busy, face_ready}, 2'b10);
         if (stalled)
            chk({tag, " stall_hold"}, {frag_valid, frag_x, frag_y, frag_color, frag_id}, {1'b1, held});
         stalled = frag_valid && !frag_ready;
         held    = {frag_x, frag_y, frag_color, frag_id};
         if (frag_valid && first_cyc < 0) first_cyc = cyc;
         if (frag_valid && frag_ready) begin
            if (exp_q.size() == 0) begin
               chk({tag, " extra_frag"}, got + 1, n_exp);
            end else begin
               p = exp_q.pop_front();
               chk({tag, " frag_xy"}, {frag_x, frag_y}, {p.x[7:0], p.y[7:0]});
               chk({tag, " frag_attr"}, {frag_color, frag_id}, {col, id});
            end
            last_xy = frag_x * 256 + frag_y;
            got++;
         end
         if (face_done) begin
            done_cnt++;
            done_cyc = cyc;
         end
         if (abort_after > 0 && got == abort_after) return;
         @(posedge clk); #1;
         cyc++;
         if (done_cyc >= 0 && cyc > done_cyc + 2) break;
      end
      chk({tag, " frag_count"}, got, n_exp);
      if (exp_cnt >= 0)   chk({tag, " frag_count_tbl"}, got, exp_cnt);
      chk({tag, " done_pulses"}, done_cnt, 1);
      if (exp_done > 0)   chk({tag, " done_latency"}, done_cyc, exp_done);
      if (exp_first > 0)  chk({tag, " first_latency"}, first_cyc, exp_first);
   endtask

   initial begin
      #900000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int last;
      reset      = 1'b1;
      face_i     = '0;
      face_id_i  = '0;
      face_valid = 1'b0;
      frag_ready = 1'b0;

      vecs[0] = '{"s1_ccw", 10, 10, 20, 10, 10, 20, 16'h1234, 7'd1, 0, 66, 124, 3};
`ifdef BACKFACE_CULL_EN
      vecs[1] = '{"s2_cw", 10, 10, 10, 20, 20, 10, 16'h0F0F, 7'd2, 0, 0, 3, -1};
`else
      vecs[1] = '{"s2_cw", 10, 10, 10, 20, 20, 10, 16'h0F0F, 7'd2, 0, 66, 124, 3};
`endif
      vecs[2] = '{"s3_colin", 5, 5, 10, 10, 15, 15, 16'hABCD, 7'd3, 0, 0, 3, -1};
      vecs[3] = '{"s4_toggle", 10, 10, 20, 10, 10, 20, 16'h5555, 7'd4, 1, 66, -1, 3};
      vecs[4] = '{"s5_clamp", 250, 250, 300, 250, 250, 300, 16'hC3C3, 7'd5, 0, 36, 39, 3};

      repeat (3) @(posedge clk);
      #1;
      chk("reset_ready_busy_done", {face_ready, busy, face_done}, 3'b100);
      chk("reset_frag_valid", frag_valid, 0);
      chk("reset_frag_fields", {frag_x, frag_y, frag_color, frag_id}, 39'd0);
      reset = 1'b0;
      @(posedge clk); #1;

      for (int n = 0; n < 5; n++) begin
         run_face(vecs[n].tag, vecs[n].x0, vecs[n].y0, vecs[n].x1, vecs[n].y1, vecs[n].x2,
                  vecs[n].y2, vecs[n].col, vecs[n].id, vecs[n].rmode, vecs[n].exp_cnt,
                  vecs[n].exp_done, vecs[n].exp_first, 0, 8'h00, last);
         if (n == 4) chk("s5_scan_end_xy", last, 255 * 256 + 255);
      end

      // Reset in the middle of a scan drops the pending fragment, no face_done
      run_face("s6_abort", 10, 10, 20, 10, 10, 20, 16'h7777, 7'd6, 0, -1, -1, -1, 5, 8'h00, last);
      @(posedge clk); #1;
      reset = 1'b1;
      @(posedge clk); #1;
      chk("s6_after_reset", {frag_valid, face_ready, busy, face_done}, 4'b0100);
      reset = 1'b0;
      exp_q.delete();
      @(negedge clk);
      chk("s6_no_done_after_reset", face_done, 0);
      @(posedge clk); #1;
      run_face("s6_new", 10, 10, 20, 10, 10, 20, 16'h2468, 7'd7, 0, 66, 124, 3, 0, 8'h00, last);

      // Random small faces, some crossing the screen edge, random back-pressure
      for (int n = 0; n < 25; n++) begin
         int bx, by;
         bx = $urandom_range(0, 250);
         by = $urandom_range(0, 250);
         run_face($sformatf("rnd%0d", n),
                  bx + $urandom_range(0, 14), by + $urandom_range(0, 14),
                  bx + $urandom_range(0, 14), by + $urandom_range(0, 14),
                  bx + $urandom_range(0, 14), by + $urandom_range(0, 14),
                  16'($urandom), 7'($urandom), 2, -1, -1, -1, 0, 8'($urandom), last);
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
`default_nettype wire
